muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Multi-cycle multiply/divide sequencer beside the single-cycle ALU in the execute stage. It accepts MULT/MULTU/DIV/DIVU requests from the decoder/controller, iterates a shared 32-bit add/shift datapath for WIDTH steps, and writes the 64-bit result into the architectural HI/LO registers. While busy it asserts a stall to the pipeline. MTHI/MTLO writes are also served here.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH.
- clock  in  1  system clock, all state changes on rising edge.
- reset_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- src_a  in  WIDTH  multiplicand / dividend (rs).
- src_b  in  WIDTH  multiplier / divisor (rt).
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  high in every state except IDLE; pipeline stall.
- done  out  1  one-cycle pulse when HI/LO hold a new result.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).
- div_zero  out  1  sticky flag: last DIV/DIVU had src_b == 0; cleared by next start.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: start=1 -> latch op, src_a, src_b; go PREP. start=0 -> stay.
- PREP: signed ops take absolute values of operands; record result sign (mult: sign_a^sign_b; div quotient: sign_a^sign_b, remainder: sign_a). Unsigned ops pass through. Clear iteration counter. -> CALC.
- CALC: one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle; counter increments; after WIDTH steps -> FIX.
- FIX: negate product / quotient / remainder per recorded signs (two's complement, 2*WIDTH-bit for product). -> DONE.
- DONE: hi/lo load final result on entry; done=1 for this cycle only; -> IDLE.
- Multiply: 2*WIDTH-bit exact product, no overflow.
- Divide by zero: full latency still taken; result HI = src_a, LO = all ones; div_zero=1.
- Signed DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0; no flag.
- Remainder sign follows dividend; quotient truncates toward zero.
- start while busy: ignored (pipeline is stalled, must not issue).
- hi_we/lo_we in IDLE: write wdata to hi/lo next edge. In any other state: ignored.
- hi_we/lo_we and start in same IDLE cycle: both act; MTHI/MTLO value is overwritten later by the result.
- hi/lo unchanged except by DONE entry or MTHI/MTLO.

## Timing
- Reset (reset_n=0 at an edge): state IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0. Applies mid-operation: operation abandoned, no done pulse.
- start sampled at edge 0 -> busy=1 from cycle 1 (PREP); CALC cycles 2..WIDTH+1; FIX cycle WIDTH+2; DONE cycle WIDTH+3 (35 for WIDTH=32) with done=1 and hi/lo valid; busy=0 and next start accepted from cycle WIDTH+4.
- busy is registered state decode; done is registered, exactly one cycle wide.
- Back-to-back: start in the first IDLE cycle after DONE is accepted; no dead cycles beyond that.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> at cycle 35 done=1, HI=0xFFFFFFFE, LO=0x00000001; busy high cycles 1..35.
- MULT 0xFFFFFFFD (-3) x 0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 0 -> done at cycle 35, HI=0x00000007, LO=0xFFFFFFFF, div_zero=1; next MULTU start clears div_zero.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0.
- Start MULTU 3x4, pulse start again with 5x6 at cycle 10 and hi_we at cycle 12 -> both ignored; result HI=0, LO=12 at cycle 35.
- Start DIVU, drop reset_n at cycle 20 -> next cycle busy=0, hi=lo=0, no done; then hi_we with 0x12345678 in IDLE -> hi=0x12345678 next cycle.

Source files
------------

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute-stage controller and the
// multiply/divide sequencer.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, src_a, src_b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, src_a, src_b, hi_we, lo_we, wdata,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One shift-add (multiply) or restoring subtract-shift (divide) step per
// CALC cycle on magnitudes; signs are applied in FIX.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// PREP  | take operand magnitudes, record result signs, clear counter
// CALC  | WIDTH iteration steps, one per cycle
// FIX   | apply signs, load HI/LO, raise done for the next cycle
// DONE  | done=1, HI/LO hold the new result
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic     clock,
  input logic     reset_n,
  muldiv_if.slave bus
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_hi_q, neg_hi_d;
  logic             neg_lo_q, neg_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_part;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] rem_fix, quo_fix;

  // Datapath terms shared by the PREP, CALC and FIX states.
  always_comb begin
    a_neg    = ~op_q[0] & a_q[WIDTH-1];
    b_neg    = ~op_q[0] & b_q[WIDTH-1];
    a_abs    = a_neg ? -a_q : a_q;
    b_abs    = b_neg ? -b_q : b_q;
    // Multiply: acc = {partial product, remaining multiplier bits}.
    mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, a_q};
    // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
    // The shifted remainder is always below 2*divisor, so the difference
    // fits in WIDTH bits.
    div_part = acc_q[AW-1:WIDTH-1];
    div_ge   = div_part >= {1'b0, b_q};
    div_diff = div_part[WIDTH-1:0] - b_q;
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    rem_fix  = neg_hi_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];
    // Divide by zero: the restoring loop already leaves |a| as remainder,
    // which the dividend sign turns back into a; quotient is forced.
    if (b_q == '0) begin
      quo_fix = '1;
    end else begin
      quo_fix = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
  end

  // Next-state and register update logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.src_a;
          b_d     = bus.src_b;
          dz_d    = 1'b0;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        a_d      = a_abs;
        b_d      = b_abs;
        acc_d    = op_q[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
        neg_lo_d = a_neg ^ b_neg;
        neg_hi_d = a_neg;
        cnt_d    = '0;
        state_d  = S_CALC;
      end
      S_CALC: begin
        if (op_q[1]) begin
          if (div_ge) acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
          else        acc_d = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else if (acc_q[0]) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[AW-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
          dz_d = (b_q == '0);
        end else begin
          hi_d = prod_fix[AW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

endmodule
